// File: rtl/seq_mult_if.sv
// Request/response bundle for the sequential multiplier.
//   start, op, dataA, dataB : request side, driven by the requester (master)
//   busy, done, dataOut     : status/result side, driven by the unit (slave)
// dataOut[2W-1:W] feeds HI, dataOut[W-1:0] feeds LO.
interface seq_mult_if #(parameter int WIDTH = 32);
  logic               start;
  logic [5:0]         op;
  logic [WIDTH-1:0]   dataA;
  logic [WIDTH-1:0]   dataB;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] dataOut;

  modport master (output start, op, dataA, dataB, input busy, done, dataOut);
  modport slave  (input start, op, dataA, dataB, output busy, done, dataOut);
endinterface

// File: rtl/seq_mult_unit.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; abandons any operation, clears dataOut
//   bus   : seq_mult_if slave
//           start/op/dataA/dataB sampled only in IDLE
//           busy high in CALC/FIX, done one-cycle pulse, dataOut holds last result
// MULT works on operand magnitudes and negates the product at the end;
// MULTU uses the operands unchanged.
module seq_mult_unit #(
  parameter int WIDTH     = 32,
  parameter int EARLY_OUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  seq_mult_if.slave   bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nx;

  logic [W2-1:0]    mcand, acc, dout;
  logic [WIDTH-1:0] mplier, mplier_sh;
  logic [CW-1:0]    cnt;
  logic             neg, done_r;
  logic             is_mult, accept, calc_last;

  // Two's-complement magnitude as an unsigned W-bit value; -2^(W-1) maps
  // to 2^(W-1), which still fits.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  assign is_mult   = (bus.op == OP_MULT);
  assign accept    = bus.start && (is_mult || bus.op == OP_MULTU);
  assign mplier_sh = mplier >> 1;
  assign calc_last = (cnt == CW'(WIDTH - 1)) ||
                     ((EARLY_OUT != 0) && (mplier_sh == '0));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = CALC;
      CALC:    if (calc_last) state_nx = FIX;
      FIX:                    state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      dout   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          mcand  <= W2'(is_mult ? mag(bus.dataA) : bus.dataA);
          mplier <= is_mult ? mag(bus.dataB) : bus.dataB;
          neg    <= is_mult && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
          acc    <= '0;
          cnt    <= '0;
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier_sh;
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          dout   <= neg ? (~acc + 1'b1) : acc;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state == CALC) || (state == FIX);
  assign bus.done    = done_r;
  assign bus.dataOut = dout;
endmodule
